controle_busca: RTL

- Instruction-fetch sequencer that drives the instruction memory ROM and hands fetched words to the decode stage.
- Owns the program counter, issues one word-aligned byte address per cycle, and captures the ROM's combinational read data into a 2-entry buffer.
- The buffer absorbs decode stalls without losing or repeating instructions.
- Handles branch/jump redirects with a flush, and stops fetching when the PC runs past the ROM depth.

---
 rtl/controle_busca.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/controle_busca.sv
// Instruction-fetch sequencer: owns the PC, reads the ROM and feeds decode through a 2-entry buffer.
// Optional macro FETCH_STATS_EN adds the push and bubble counters cont_busca / cont_bolha.
module controle_busca #(
    parameter int unsigned MEM_WORDS    = 51,
    parameter logic [31:0] ADDR_INICIAL = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] endereco,
    input  logic [31:0] instrucao_mem,
    input  logic        habilitar,
    input  logic        desvio,
    input  logic [31:0] alvo_desvio,
    output logic [31:0] instrucao,
    output logic [31:0] pc_instrucao,
    output logic        valido,
    input  logic        pronto,
    output logic        fora_limite
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] cont_busca,
    output logic [31:0] cont_bolha
`endif
);

    localparam int unsigned XLEN      = 32;
    localparam logic [XLEN-1:0] LIMITE    = XLEN'(MEM_WORDS);
    localparam logic [XLEN-1:0] MASCARA   = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] PC_RESET  = ADDR_INICIAL & MASCARA;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        CHEIO  = 2'd2,
        ERRO   = 2'd3
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] cab_instr_q, cab_instr_d;
    logic [XLEN-1:0] cab_pc_q, cab_pc_d;
    logic [XLEN-1:0] cau_instr_q, cau_instr_d;
    logic [XLEN-1:0] cau_pc_q, cau_pc_d;
    logic            fora_q, fora_d;

    logic pop;
    logic espaco;
    logic no_limite;
    logic push;
    logic bloqueio;

    assign valido       = (cnt_q != 2'd0);
    assign endereco     = pc_q;
    assign instrucao    = cab_instr_q;
    assign pc_instrucao = cab_pc_q;
    assign fora_limite  = fora_q;

    assign pop       = valido && pronto;
    assign espaco    = (cnt_q != 2'd2) || pop;
    assign no_limite = ({2'b00, pc_q[XLEN-1:2]} < LIMITE);
    assign push      = habilitar && !desvio && no_limite && espaco;
    assign bloqueio  = habilitar && !desvio && !no_limite && espaco;

    // Buffer and PC update; a redirect flushes without disturbing the visible head.
    always_comb begin
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        cab_instr_d = cab_instr_q;
        cab_pc_d    = cab_pc_q;
        cau_instr_d = cau_instr_q;
        cau_pc_d    = cau_pc_q;
        if (desvio) begin
            cnt_d = 2'd0;
            pc_d  = alvo_desvio & MASCARA;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        cab_instr_d = instrucao_mem;
                        cab_pc_d    = pc_q;
                        cnt_d       = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        cab_instr_d = instrucao_mem;
                        cab_pc_d    = pc_q;
                    end else if (push) begin
                        cau_instr_d = instrucao_mem;
                        cau_pc_d    = pc_q;
                        cnt_d       = 2'd2;
                    end else if (pop) begin
                        cnt_d = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        cab_instr_d = cau_instr_q;
                        cab_pc_d    = cau_pc_q;
                        if (push) begin
                            cau_instr_d = instrucao_mem;
                            cau_pc_d    = pc_q;
                        end else begin
                            cnt_d = 2'd1;
                        end
                    end
                end
            endcase
            if (push) begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // Next-state logic; ERRO is left only through a redirect or reset.
    always_comb begin
        estado_d = estado_q;
        if (desvio) begin
            estado_d = habilitar ? BUSCA : OCIOSO;
        end else if (estado_q == ERRO) begin
            estado_d = ERRO;
        end else if (!habilitar) begin
            estado_d = OCIOSO;
        end else if (bloqueio) begin
            estado_d = ERRO;
        end else if ((cnt_d == 2'd2) && !pop) begin
            estado_d = CHEIO;
        end else begin
            estado_d = BUSCA;
        end
        fora_d = (estado_d == ERRO);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            pc_q        <= PC_RESET;
            cnt_q       <= 2'd0;
            cab_instr_q <= '0;
            cab_pc_q    <= '0;
            cau_instr_q <= '0;
            cau_pc_q    <= '0;
            fora_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            cab_instr_q <= cab_instr_d;
            cab_pc_q    <= cab_pc_d;
            cau_instr_q <= cau_instr_d;
            cau_pc_q    <= cau_pc_d;
            fora_q      <= fora_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [XLEN-1:0] cont_busca_q;
    logic [XLEN-1:0] cont_bolha_q;

    // Counters ignore redirects; only reset clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_busca_q <= '0;
            cont_bolha_q <= '0;
        end else begin
            if (push) begin
                cont_busca_q <= cont_busca_q + 32'd1;
            end
            if (habilitar && !valido) begin
                cont_bolha_q <= cont_bolha_q + 32'd1;
            end
        end
    end

    assign cont_busca = cont_busca_q;
    assign cont_bolha = cont_bolha_q;
`endif

endmodule
